// File: rtl/universal_shift_register_pkg.sv
// Shared mode and direction codes for the universal shift register and its users.
package universal_shift_register_pkg;

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_SHIFT  = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;
  localparam logic [1:0] MODE_BOUNCE = 2'b11;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/universal_shift_register_strobe_timer.sv
// Programmable-period prescaler: strobe is high for one cycle whenever the counter is at zero.
module strobe_timer #(
  parameter int PERIOD = 4194304,
  parameter int CNT_W  = 22
) (
  input  logic clock,
  input  logic reset_n,
  output logic strobe
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] count;

  // Counter resets to zero so the first strobe lands in the first cycle after release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign strobe = (count == '0);

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit hold/shift/rotate/bounce register stepped by an internal strobe, with priority parallel load.
module universal_shift_register
  import universal_shift_register_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int PERIOD = 4194304,
  parameter int CNT_W  = 22
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             serial_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             step,
  output logic             bounce_dir
);

  logic [WIDTH-1:0] q_next;
  logic             serial_out_next;
  logic             bounce_dir_next;

  strobe_timer #(
    .PERIOD (PERIOD),
    .CNT_W  (CNT_W)
  ) u_strobe_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .strobe  (step)
  );

  // Load wins over a coincident step, which is then simply dropped.
  always_comb begin
    q_next          = q;
    serial_out_next = serial_out;
    bounce_dir_next = bounce_dir;
    if (load) begin
      q_next = load_data;
    end else if (step) begin
      case (mode)
        MODE_HOLD: ;
        MODE_SHIFT: begin
          if (dir == DIR_LEFT) begin
            q_next          = {q[WIDTH-2:0], serial_in};
            serial_out_next = q[WIDTH-1];
          end else begin
            q_next          = {serial_in, q[WIDTH-1:1]};
            serial_out_next = q[0];
          end
        end
        MODE_ROTATE: begin
          if (dir == DIR_LEFT) begin
            q_next = {q[WIDTH-2:0], q[WIDTH-1]};
          end else begin
            q_next = {q[0], q[WIDTH-1:1]};
          end
        end
        MODE_BOUNCE: begin
          // Turn around on the step that reaches an end, so the token never dwells there.
          if (q == '0) begin
            q_next          = WIDTH'(1);
            bounce_dir_next = DIR_LEFT;
          end else if (bounce_dir == DIR_LEFT) begin
            if (q[WIDTH-1]) begin
              q_next          = q >> 1;
              bounce_dir_next = DIR_RIGHT;
            end else begin
              q_next = q << 1;
            end
          end else begin
            if (q[0]) begin
              q_next          = q << 1;
              bounce_dir_next = DIR_LEFT;
            end else begin
              q_next = q >> 1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q          <= '0;
      serial_out <= 1'b0;
      bounce_dir <= DIR_LEFT;
    end else begin
      q          <= q_next;
      serial_out <= serial_out_next;
      bounce_dir <= bounce_dir_next;
    end
  end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
- Parametrised successor of the board-level LED shift register.
- WIDTH-bit register that steps once per strobe from an internal programmable-period timer.
- Step modes: hold, shift, rotate and bounce, with a selectable direction and a synchronous parallel load.
- Sits between debounced board inputs (keys/switches) and the LED bank, or in any datapath that needs a slow, visible shifter.

Parameters:
- WIDTH, 10, register width in bits; must be >= 2.
- PERIOD, 4194304, clock cycles between step strobes; must be >= 1; PERIOD = 1 means a strobe every cycle.
- CNT_W, 22, prescaler counter width; must satisfy 2^CNT_W >= PERIOD.

Ports:
- clock  input  1  system clock, 12 MHz on the board.
- reset_n  input  1  asynchronous active-low reset.
- mode  input  2  00 HOLD, 01 SHIFT, 10 ROTATE, 11 BOUNCE.
- dir  input  1  0 = right (toward bit 0), 1 = left (toward bit WIDTH-1); used by SHIFT and ROTATE only.
- serial_in  input  1  fill bit for SHIFT mode.
- load  input  1  synchronous parallel load request.
- load_data  input  WIDTH  value written by load.
- q  output  WIDTH  register contents.
- serial_out  output  1  bit shifted out on the most recent SHIFT step.
- step  output  1  one-cycle strobe marking the cycle in which q may update.
- bounce_dir  output  1  current BOUNCE direction (0 right, 1 left).

Behaviour:
- Reset (async, reset_n = 0): q = 0, serial_out = 0, bounce_dir = 1 (left), prescaler counter = 0.
- Prescaler: counter runs 0..PERIOD-1 and wraps to 0.
  - step = (counter == 0), combinational from the registered counter.
  - The first step is in the first cycle after reset release; thereafter one step every PERIOD cycles.
  - load does not affect the counter.
- Priority per rising edge: load > step > hold.
- load = 1: q <= load_data in that cycle, whether or not step is high.
  - serial_out and bounce_dir are unchanged.
  - A step coincident with load is consumed; no shift occurs.
- step = 1, load = 0: mode and dir are sampled in that cycle; the result is visible the cycle after the step cycle.
  - HOLD: q unchanged.
  - SHIFT, right: q <= {serial_in, q[WIDTH-1:1]}; serial_out <= old q[0].
  - SHIFT, left: q <= {q[WIDTH-2:0], serial_in}; serial_out <= old q[WIDTH-1].
  - ROTATE, right: q <= {q[0], q[WIDTH-1:1]}.
  - ROTATE, left: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - serial_out is unchanged in ROTATE.
- BOUNCE (dir and serial_in ignored; zero fill; serial_out unchanged):
  - q == 0: q <= 1 (seed bit 0), bounce_dir <= 1.
  - bounce_dir = 1 and old q[WIDTH-1] = 1: bounce_dir <= 0, q <= q >> 1.
  - bounce_dir = 1 otherwise: q <= q << 1.
  - bounce_dir = 0 and old q[0] = 1: bounce_dir <= 1, q <= q << 1.
  - bounce_dir = 0 otherwise: q <= q >> 1.
  - Result: a single token sweeps 0 -> WIDTH-1 -> 0 with no dwell at the ends.
- bounce_dir keeps its value when leaving BOUNCE and is reused on re-entry.
- Mode or dir changes between strobes have no effect until the next step.
- Reset asserted mid-sweep or mid-period returns everything to reset values immediately.
- No X propagation: every register has a defined reset value.

Decomposition:
- Shared package (include file): mode code constants MODE_HOLD, MODE_SHIFT, MODE_ROTATE, MODE_BOUNCE, and direction constants DIR_RIGHT, DIR_LEFT.
- Sub-module strobe_timer (parameters PERIOD, CNT_W; ports clock, reset_n, strobe): the prescaler.
- The rest is one always block plus next-state logic.
- Top-level board wrapper maps key[0] to reset_n and the inverted key[1] to serial_in; LEDs show q.

Test Plan:
- WIDTH=8, PERIOD=4, reset then release -> step high in cycle 1, 5, 9, ...; q = 0x00, bounce_dir = 1, serial_out = 0.
- SHIFT right with serial_in = 1 for 3 steps, then 0 -> q = 0x80, 0xC0, 0xE0, 0x70.
  - Then load 0x01 and shift right once -> serial_out = 1, q = 0x00.
- ROTATE left from loaded 0x81 -> 0x03, 0x06 on successive steps.
  - dir changed to right between steps -> next step gives 0x03.
- BOUNCE from q = 0 -> q = 0x01, 0x02, ..., 0x80, then 0x40 with bounce_dir = 0, ... down to 0x01, then 0x02 with bounce_dir = 1.
- load asserted in the same cycle as step with mode = SHIFT, load_data = 0x5A -> q = 0x5A, no shift, serial_out unchanged.
  - The next step shifts normally.
- reset_n pulsed low mid-period during BOUNCE at q = 0x10 -> q = 0 asynchronously.
  - After release, step occurs one cycle later.
  - PERIOD=1 run -> a step every cycle.
